// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : UART transmitter with configurable framing and a write FIFO
// Revision     : 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 two_stop,
  output logic                 TX,
  output logic                 tx_done,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 overrun
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [15:0]     BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]      DBIT_LAST = 3'(DATA_BITS - 1);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [15:0]          baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 ovr_q;
  logic                 push, pop, tick, frame_end;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign fifo_full = (count_q == DEPTH_C);
  assign push      = trmt & ~fifo_full;
  assign tick      = (baud_q == BAUD_LAST);

  assign TX        = tx_q;
  assign tx_done   = done_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign overrun   = ovr_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    pop        = 1'b0;
    frame_end  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = tick ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      IDLE: tx_d = 1'b1;
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == DBIT_LAST) begin
            bit_d = 3'd0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (two_stop_q && (bit_q == 3'd0)) begin
            bit_d = 3'd1;
          end else begin
            frame_end = 1'b1;
            bit_d     = 3'd0;
            state_d   = IDLE;
            tx_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Framing options are captured with the word so mid-frame changes wait for the next frame.
    if (((state_q == IDLE) || frame_end) && (count_q != '0)) begin
      pop        = 1'b1;
      state_d    = START;
      baud_d     = 16'd0;
      bit_d      = 3'd0;
      tx_d       = 1'b0;
      sh_d       = mem_q[rd_ptr_q];
      par_en_d   = par_en;
      par_bit_d  = (^mem_q[rd_ptr_q]) ^ par_odd;
      two_stop_d = two_stop;
    end

    count_d = count_q + CW'(push) - CW'(pop);

    if (push) begin
      done_d = 1'b0;
    end else if (frame_end && (count_q == '0)) begin
      done_d = 1'b1;
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sh_q       <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sh_q       <= sh_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      ovr_q      <= trmt & fifo_full;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo : self-checking bench for uart_tx_fifo against a frame-level model
// Revision        : 1.0
// ============================================================================
module tb_uart_tx_fifo;

  localparam int BAUD  = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trmt = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          par_en = 1'b0;
  logic          par_odd = 1'b0;
  logic          two_stop = 1'b0;
  logic          TX, tx_done, busy, fifo_full, overrun;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  uart_tx_fifo #(
    .BAUD_DIV  (BAUD),
    .DATA_BITS (DB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .two_stop (two_stop),
    .TX       (TX),
    .tx_done  (tx_done),
    .busy     (busy),
    .fifo_full(fifo_full),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: queued words plus the line levels of the frame in flight, one entry per bit.
  logic [DB-1:0] mq[$];
  bit            line[$];
  int            bclk;
  bit            m_done, m_ovr;

  always @(posedge clk or negedge rst_n) begin : model
    bit            full_pre, ne_pre, act_pre, fend;
    logic [DB-1:0] w;
    if (!rst_n) begin
      mq.delete();
      line.delete();
      bclk   = 0;
      m_done = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      full_pre = (mq.size() == DEPTH);
      ne_pre   = (mq.size() != 0);
      act_pre  = (line.size() != 0);
      fend     = 1'b0;
      if (act_pre) begin
        bclk++;
        if (bclk == BAUD) begin
          bclk = 0;
          void'(line.pop_front());
          fend = (line.size() == 0);
        end
      end
      if ((!act_pre || fend) && ne_pre) begin
        w = mq.pop_front();
        bclk = 0;
        line.push_back(1'b0);
        for (int i = 0; i < DB; i++) line.push_back(w[i]);
        if (par_en) line.push_back((^w) ^ par_odd);
        line.push_back(1'b1);
        if (two_stop) line.push_back(1'b1);
      end
      m_ovr = trmt && full_pre;
      if (trmt && !full_pre) begin
        mq.push_back(tx_data);
        m_done = 1'b0;
      end else if (fend && !ne_pre) begin
        m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check_eq("TX",        32'(TX),        32'((line.size() != 0) ? line[0] : 1'b1));
      check_eq("busy",      32'(busy),      32'((line.size() != 0) || (mq.size() != 0)));
      check_eq("tx_done",   32'(tx_done),   32'(m_done));
      check_eq("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      check_eq("overrun",   32'(overrun),   32'(m_ovr));
    end
  end

  task automatic push_word(input logic [DB-1:0] d);
    trmt    = 1'b1;
    tx_data = d;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_TX",        32'(TX),        32'd1);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_tx_done",   32'(tx_done),   32'd0);
    check_eq("rst_fifo_full", 32'(fifo_full), 32'd0);
    check_eq("rst_overrun",   32'(overrun),   32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // 8N1 0xA5, start bit two clocks after the write
    push_word(8'hA5);
    trmt = 1'b0;
    check_eq("lat_a5_pre", 32'(TX), 32'd1);
    @(negedge clk);
    check_eq("lat_a5_start", 32'(TX), 32'd0);
    wait_idle("idle_a5");
    check_eq("done_a5", 32'(tx_done), 32'd1);

    // even parity, two stop bits
    par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b1;
    push_word(8'h53);
    trmt = 1'b0;
    wait_idle("idle_53");
    check_eq("done_53", 32'(tx_done), 32'd1);

    // parity mode flipped mid-frame with a second word queued
    par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b0;
    push_word(8'h5A);
    push_word(8'h3C);
    trmt = 1'b0;
    repeat (10) @(negedge clk);
    par_odd = 1'b1;
    wait_idle("idle_par_toggle");

    // three back-to-back frames, 8N1
    par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    trmt = 1'b0;
    check_eq("done_low_3", 32'(tx_done), 32'd0);
    wait_idle("idle_3");
    check_eq("done_3", 32'(tx_done), 32'd1);

    // six writes in six clocks: one to the shifter, four queued, one dropped
    for (int i = 0; i < 6; i++) push_word(DB'($urandom));
    trmt = 1'b0;
    check_eq("full_after_6", 32'(fifo_full), 32'd1);
    wait_idle("idle_6");

    // randomized traffic with occasional framing changes
    for (int c = 0; c < 3000; c++) begin
      trmt    = ($urandom_range(0, 7) == 0);
      tx_data = DB'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        par_en   = 1'($urandom_range(0, 1));
        par_odd  = 1'($urandom_range(0, 1));
        two_stop = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    trmt = 1'b0;
    wait_idle("idle_rand");

    // reset during the data bits with two words still queued
    par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
    push_word(8'h00);
    push_word(8'h00);
    push_word(8'h00);
    trmt = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    check_eq("pre_rst_TX", 32'(TX), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_TX",   32'(TX),        32'd1);
    check_eq("async_rst_busy", 32'(busy),      32'd0);
    check_eq("async_rst_full", 32'(fifo_full), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("post_rst_busy", 32'(busy),    32'd0);
    check_eq("post_rst_done", 32'(tx_done), 32'd0);
    check_eq("post_rst_TX",   32'(TX),      32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised successor to the fixed 8N1/115200 UART transmitter: configurable bit period, data width, parity and stop-bit count, fronted by a small write FIFO so the host can queue bytes without waiting for each frame. Sits between the e-bike control/telemetry logic and the serial TX pin. Frames are sent back-to-back with no idle gap while the FIFO holds data.

## Interface

Parameters:
- BAUD_DIV, 434: clocks per bit (50 MHz / 115200); legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- FIFO_DEPTH, 4: FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- trmt  in  1  write strobe; pushes tx_data into the FIFO when sampled high.
- tx_data  in  DATA_BITS  word to queue.
- par_en  in  1  1 = append a parity bit.
- par_odd  in  1  1 = odd parity, 0 = even; ignored when par_en=0.
- two_stop  in  1  1 = two stop bits, 0 = one.
- TX  out  1  serial line, idle high.
- tx_done  out  1  level: set when the last queued frame completes; cleared by an accepted write.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_full  out  1  high when FIFO count == FIFO_DEPTH.
- overrun  out  1  one-cycle pulse when trmt is dropped because the FIFO is full.

## Operation

- Reset values: TX=1, tx_done=0, busy=0, fifo_full=0, overrun=0, FIFO empty, state IDLE, baud and bit counters 0.
- Push: trmt=1 and fifo_full=0 → write tx_data, count+1, tx_done←0. trmt=1 and fifo_full=1 → word dropped, overrun=1 next cycle, FIFO unchanged. Fullness is judged before any same-cycle pop: a push is rejected while full even when a pop happens in that cycle.
- Pop: when IDLE with FIFO non-empty, or at the edge ending the last stop bit with FIFO non-empty, the head word moves into the shift register. par_en, par_odd and two_stop are latched at that moment; mid-frame changes have no effect until the next frame.
- Frame order: start bit (0), DATA_BITS data bits LSB first, optional parity bit, then 1 or 2 stop bits (1).
- Parity bit = XOR of the data bits, inverted when par_odd=1.
- Frame length = 2 + DATA_BITS + par_en + two_stop bits.
- State machine: IDLE → START (on pop) → DATA (after 1 bit time) → PARITY if par_en, else STOP → STOP. After the final stop bit: START if FIFO non-empty (pop that edge), else IDLE.
- Bit counter counts data bits 0..DATA_BITS-1 and stop bits 0..1.
- Baud counter: cleared on pop; increments each clock; at BAUD_DIV-1 it wraps to 0 and advances the bit. Every bit is exactly BAUD_DIV clocks.
- tx_done is set at the edge ending the final stop bit only when the FIFO is empty at that edge.
- If that edge coincides with an accepted push, the push wins and tx_done stays 0 (the new word pops on the next cycle from IDLE).
- TX is registered, glitch-free, and 1 in IDLE.
- Reset mid-frame: TX returns to 1 immediately (asynchronously); FIFO contents and the frame in progress are discarded.

## Timing

- Write-to-line latency, idle block with empty FIFO: trmt sampled at edge E0 (write), pop at E1, TX=0 from E1 onward. Two clocks.
- Back-to-back: the next start bit begins on the clock immediately after the previous stop bit's final cycle; zero idle clocks.
- fifo_full and busy update on the edge after the push/pop that changes count.
- busy falls on the same edge that sets tx_done.
- Frame duration: (2 + DATA_BITS + par_en + two_stop) × BAUD_DIV clocks.
- Maximum queued: FIFO_DEPTH words plus one in the shift register.

## Test plan

- 8N1, BAUD_DIV=4, write 0xA5 → TX: 0 then 1,0,1,0,0,1,0,1 then 1, each bit 4 clocks. Start bit at write+2. tx_done=1 after 40 clocks of frame; busy=0 at that edge.
- DATA_BITS=7, par_en=1, par_odd=0, two_stop=1, write 0x53 → data 1,1,0,0,1,0,1; parity 0; two stop bits; 11 bits × BAUD_DIV.
- par_odd toggled mid-frame → current frame's parity unchanged; the next queued frame uses the new mode.
- Three consecutive writes 0x01,0x02,0x03 → three frames with zero idle clocks between them. tx_done stays 0 until the third stop bit ends.
- FIFO_DEPTH=4: six writes in six consecutive clocks → first pops to the shifter, next four fill the FIFO, sixth dropped with a single overrun pulse. fifo_full asserts; exactly five frames are sent.
- rst_n low during the DATA bits of a frame with two words queued → TX=1 immediately; after release, no further frames; busy=0, tx_done=0.
